// File: rtl/ones_iter.sv
// ones_iter: emits the index of every set bit of a loaded vector, lowest index first, one per handshake.
// Optional feature: define ONES_ITER_ABORT_EN to add an abort input that drops a vector mid-emission.
module ones_iter #(
    parameter  int LOG_VEC_SIZE = 3,
    localparam int VEC_SIZE     = 1 << LOG_VEC_SIZE
) (
    input  logic                    clk,
    input  logic                    resetN,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [0:VEC_SIZE-1]     vec,
    output logic                    idx_valid,
    input  logic                    idx_ready,
    output logic [LOG_VEC_SIZE-1:0] idx,
    output logic                    idx_last,
    output logic [LOG_VEC_SIZE:0]   remaining,
    output logic                    busy,
`ifdef ONES_ITER_ABORT_EN
    input  logic                    abort,
`endif
    output logic                    done
);
    typedef enum logic {IDLE, EMIT} state_t;

    state_t                  r_state, w_state_next;
    logic [0:VEC_SIZE-1]     r_vec, w_vec_clr, w_vec_next;
    logic [LOG_VEC_SIZE-1:0] r_idx, w_idx_next;
    logic [LOG_VEC_SIZE:0]   r_remaining, w_rem_next;
    logic                    r_idx_valid, r_idx_last, r_done, w_done_next;
    logic                    w_load, w_xfer, w_abort;

    function automatic logic [LOG_VEC_SIZE:0] f_popcount(input logic [0:VEC_SIZE-1] v);
        logic [LOG_VEC_SIZE:0] c;
        c = '0;
        for (int i = 0; i < VEC_SIZE; i++) c = c + (LOG_VEC_SIZE+1)'(v[i]);
        return c;
    endfunction

    function automatic logic [LOG_VEC_SIZE-1:0] f_lowest(input logic [0:VEC_SIZE-1] v);
        logic [LOG_VEC_SIZE-1:0] l;
        l = '0;
        for (int i = VEC_SIZE - 1; i >= 0; i--) if (v[i]) l = LOG_VEC_SIZE'(i);
        return l;
    endfunction

    assign w_load = (r_state == IDLE) && load_valid;
    assign w_xfer = r_idx_valid && idx_ready;
`ifdef ONES_ITER_ABORT_EN
    assign w_abort = (r_state == EMIT) && abort;
`else
    assign w_abort = 1'b0;
`endif

    // Next state and next values of the registered outputs; abort beats transfer, load only from IDLE.
    always_comb begin
        w_vec_clr         = r_vec;
        w_vec_clr[r_idx]  = 1'b0;
        w_vec_next   = w_abort ? '0 : w_load ? vec : w_xfer ? w_vec_clr : r_vec;
        w_rem_next   = w_abort ? '0 : w_load ? f_popcount(vec) : w_xfer ? r_remaining - 1'b1 : r_remaining;
        w_idx_next   = (w_rem_next != '0) ? f_lowest(w_vec_next) : '0;
        w_done_next  = !w_abort && ((w_load && vec == '0) || (w_xfer && r_idx_last));
        w_state_next = r_state;
        if (r_state == IDLE)
            w_state_next = (w_load && vec != '0) ? EMIT : IDLE;
        else if (w_abort || (w_xfer && r_idx_last))
            w_state_next = IDLE;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!resetN) r_state <= IDLE;
        else         r_state <= w_state_next;
    end

    // Datapath registers: latched vector, current index, count and status flags.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            r_vec       <= '0;
            r_idx       <= '0;
            r_remaining <= '0;
            r_idx_valid <= 1'b0;
            r_idx_last  <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_vec       <= w_vec_next;
            r_idx       <= w_idx_next;
            r_remaining <= w_rem_next;
            r_idx_valid <= w_rem_next != '0;
            r_idx_last  <= w_rem_next == (LOG_VEC_SIZE+1)'(1);
            r_done      <= w_done_next;
        end
    end

    assign load_ready = r_state == IDLE;
    assign busy       = r_state == EMIT;
    assign idx_valid  = r_idx_valid;
    assign idx        = r_idx;
    assign idx_last   = r_idx_last;
    assign remaining  = r_remaining;
    assign done       = r_done;
endmodule

// File: tb/tb_ones_iter.sv
// tb_ones_iter: directed vectors for ones_iter, checked by a queue-based scoreboard and monitor.
module tb_ones_iter;
    typedef struct {
        bit is_done;
        int idx;
        bit last;
        int rem;
    } item_t;

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic       load_valid = 1'b0;
    logic       load_ready;
    logic [0:7] vec = '0;
    logic       idx_valid;
    logic       idx_ready = 1'b0;
    logic [2:0] idx;
    logic       idx_last;
    logic [3:0] remaining;
    logic       busy;
    logic       done;
    logic       abort = 1'b0;

    int    tests = 0;
    int    fails = 0;
    item_t sb[$];

    ones_iter #(.LOG_VEC_SIZE(3)) dut (
        .clk(clk), .resetN(resetN), .load_valid(load_valid), .load_ready(load_ready),
        .vec(vec), .idx_valid(idx_valid), .idx_ready(idx_ready), .idx(idx),
        .idx_last(idx_last), .remaining(remaining), .busy(busy),
`ifdef ONES_ITER_ABORT_EN
        .abort(abort),
`endif
        .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_idx(input int i, input int rem);
        item_t e;
        e.is_done = 1'b0; e.idx = i; e.last = (rem == 1); e.rem = rem;
        sb.push_back(e);
    endtask

    task automatic exp_done();
        item_t e;
        e.is_done = 1'b1; e.idx = 0; e.last = 1'b0; e.rem = 0;
        sb.push_back(e);
    endtask

    task automatic load(input logic [7:0] v);
        vec = v;
        load_valid = 1'b1;
        step();
        load_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 64; i++) begin
            if (load_ready && !done && sb.size() == 0) return;
            step();
        end
        chk({name, "_timeout"}, 1, 0);
    endtask

    // Monitor: every transfer and every done pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        item_t e;
        if (resetN) begin
            if (idx_valid && idx_ready && !abort) begin
                if (sb.size() == 0) chk("unexpected_xfer", int'(idx), -1);
                else begin
                    e = sb.pop_front();
                    chk("xfer_kind", 0, int'(e.is_done));
                    chk("xfer_idx", int'(idx), e.idx);
                    chk("xfer_last", int'(idx_last), int'(e.last));
                    chk("xfer_rem", int'(remaining), e.rem);
                end
            end
            if (done) begin
                if (sb.size() == 0) chk("unexpected_done", 1, 0);
                else begin
                    e = sb.pop_front();
                    chk("done_kind", 1, int'(e.is_done));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int exp030[4] = '{0, 3, 4, 5};
        repeat (3) step();
        chk("rst_idx_valid", int'(idx_valid), 0);
        chk("rst_remaining", int'(remaining), 0);
        chk("rst_done", int'(done), 0);
        resetN = 1'b1;
        step();
        chk("rst_load_ready", int'(load_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_idx", int'(idx), 0);
        chk("rst_idx_last", int'(idx_last), 0);

        // Four set bits streamed back to back; a load offered during the last transfer is ignored.
        exp_idx(0, 4); exp_idx(3, 3); exp_idx(4, 2); exp_idx(5, 1); exp_done();
        idx_ready = 1'b1;
        load(8'b1001_1100);
        chk("v1_busy", int'(busy), 1);
        for (int k = 0; k < 4; k++) begin
            chk("v1_valid", int'(idx_valid), 1);
            chk("v1_idx", int'(idx), exp030[k]);
            chk("v1_last", int'(idx_last), int'(k == 3));
            if (k == 3) begin vec = '0; load_valid = 1'b1; end
            step();
            load_valid = 1'b0;
        end
        chk("v1_done", int'(done), 1);
        chk("v1_valid_end", int'(idx_valid), 0);
        step();
        chk("v1_done_once", int'(done), 0);
        wait_idle("v1");

        // Empty vector: no index, only a done pulse.
        exp_done();
        load(8'b0000_0000);
        chk("v2_valid", int'(idx_valid), 0);
        chk("v2_done", int'(done), 1);
        chk("v2_load_ready", int'(load_ready), 1);
        step();
        chk("v2_done_once", int'(done), 0);
        chk("v2_valid2", int'(idx_valid), 0);

        // Single set bit held under back-pressure.
        exp_idx(1, 1); exp_done();
        idx_ready = 1'b0;
        load(8'b0100_0000);
        for (int k = 0; k < 3; k++) begin
            chk("v3_hold_valid", int'(idx_valid), 1);
            chk("v3_hold_idx", int'(idx), 1);
            chk("v3_hold_last", int'(idx_last), 1);
            chk("v3_hold_rem", int'(remaining), 1);
            step();
        end
        idx_ready = 1'b1;
        step();
        idx_ready = 1'b0;
        chk("v3_done", int'(done), 1);
        chk("v3_idle", int'(load_ready), 1);
        step();

        // All ones with toggling ready and a stray load during emission.
        for (int i = 0; i < 8; i++) exp_idx(i, 8 - i);
        exp_done();
        load(8'b1111_1111);
        chk("v4_rem_start", int'(remaining), 8);
        for (int c = 0; c < 40 && !load_ready; c++) begin
            idx_ready = ~idx_ready;
            vec = '0;
            load_valid = (c == 3);
            step();
        end
        load_valid = 1'b0;
        idx_ready = 1'b1;
        wait_idle("v4");

        // Reset in the middle of emission discards the rest.
        exp_idx(0, 5); exp_idx(2, 4);
        load(8'b1011_1010);
        step();
        step();
        resetN = 1'b0;
        idx_ready = 1'b0;
        step();
        resetN = 1'b1;
        chk("v5_valid", int'(idx_valid), 0);
        chk("v5_rem", int'(remaining), 0);
        chk("v5_done", int'(done), 0);
        chk("v5_sb_empty", sb.size(), 0);
        step();
        chk("v5_no_done", int'(done), 0);
        for (int i = 0; i < 7; i++) exp_idx(i, 7 - i);
        exp_done();
        load(8'b1111_1110);
        chk("v5_rem_start", int'(remaining), 7);
        idx_ready = 1'b1;
        wait_idle("v5");

`ifdef ONES_ITER_ABORT_EN
        // Abort on the third index wins over the simultaneous transfer.
        exp_idx(0, 5); exp_idx(2, 4);
        load(8'b1011_1010);
        step();
        step();
        chk("ab_idx3", int'(idx), 3);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("ab_valid", int'(idx_valid), 0);
        chk("ab_rem", int'(remaining), 0);
        chk("ab_done", int'(done), 0);
        chk("ab_idle", int'(load_ready), 1);
        step();
        chk("ab_no_done", int'(done), 0);
        // Abort while idle must not block a load.
        exp_idx(1, 1); exp_done();
        abort = 1'b1;
        load(8'b0100_0000);
        abort = 1'b0;
        chk("ab_idle_load", int'(idx_valid), 1);
        wait_idle("ab");
`endif

        step();
        chk("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ones_iter.md
ONES_ITER -- requirements
Module: ones_iter

Interface
REQ-001 Parameter LOG_VEC_SIZE, default 3, log2 of vector width; VEC_SIZE = 1<<LOG_VEC_SIZE.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 resetN  input  1  reset, synchronous, active-low.
REQ-004 load_valid  input  1  vec is offered for loading.
REQ-005 load_ready  output  1  block accepts a load this cycle; high exactly when state is IDLE.
REQ-006 vec  input  VEC_SIZE  bit vector, declared [0:VEC_SIZE-1]; bit i is vec[i].
REQ-007 idx_valid  output  1  idx holds a valid set-bit index.
REQ-008 idx_ready  input  1  consumer accepts idx.
REQ-009 idx  output  LOG_VEC_SIZE  index of the current set bit.
REQ-010 idx_last  output  1  current idx is the final set bit of the loaded vector.
REQ-011 remaining  output  LOG_VEC_SIZE+1  number of set bits not yet handshaked.
REQ-012 busy  output  1  high in EMIT.
REQ-013 done  output  1  one-cycle pulse at the end of each loaded vector.

Function
REQ-014 The block SHALL be the per-bit reader of a ones vector: it emits the index of every set bit, one per handshake, in ascending index order (vec[0] first).
REQ-015 FSM states: IDLE and EMIT only.
REQ-016 IDLE: load_valid high -> latch vec, and remaining = popcount(vec) at the same edge; nonzero vec -> EMIT; zero vec -> stay IDLE and pulse done next cycle.
REQ-017 Load latency: load accepted at edge N -> idx_valid=1 with the lowest set index during cycle N+1.
REQ-018 Handshake: transfer occurs when idx_valid && idx_ready at a rising edge.
REQ-019 On transfer, the emitted bit is cleared, remaining decrements by 1, and the next-lowest set index appears the following cycle with no bubble.
REQ-020 idx_valid && !idx_ready -> idx, idx_last and remaining SHALL hold stable; idx_valid SHALL NOT drop.
REQ-021 idx_last = (remaining == 1) while idx_valid; it is 0 otherwise.
REQ-022 Transfer with idx_last -> IDLE next cycle with idx_valid=0, remaining=0, done=1 for exactly one cycle.
REQ-023 load_valid in EMIT is ignored (load_ready=0), including in the cycle of the last transfer; a new load is accepted no earlier than the following cycle.
REQ-024 All-ones vector -> remaining loads VEC_SIZE (needs the extra bit); exactly VEC_SIZE transfers follow, indices 0..VEC_SIZE-1.
REQ-025 idx, idx_valid, idx_last, remaining and done SHALL be registered outputs; load_ready and busy decode directly from state.

Reset
REQ-026 resetN=0 at an edge -> state IDLE, latched vector cleared, idx_valid=0, idx=0, idx_last=0, remaining=0, done=0, busy=0, load_ready=1 from the next cycle.
REQ-027 Reset mid-EMIT SHALL discard all pending indices; done SHALL NOT pulse.

Configuration
REQ-028 Macro ONES_ITER_ABORT_EN defined -> input port abort (1 bit) exists; abort=1 in EMIT -> IDLE next cycle, vector cleared, idx_valid=0, remaining=0, no done pulse; abort has priority over a simultaneous transfer; abort in IDLE has no effect and does not block a load.
REQ-029 ONES_ITER_ABORT_EN undefined -> abort port absent; behaviour as REQ-014..REQ-027 only.

Verification
REQ-030 Load 8'b1001_1100 with idx_ready=1 -> idx 0,3,4,5 on consecutive cycles; remaining 4,3,2,1; idx_last only on 5; done one cycle later.
REQ-031 Load 8'b0000_0000 -> idx_valid never rises; done pulses once, one cycle after load; load_ready stays 1.
REQ-032 Load 8'b0100_0000 with idx_ready=0 for 3 cycles, then 1 -> idx=1, idx_last=1 held for 3 cycles; single transfer; then IDLE.
REQ-033 Load 8'b1111_1111, toggle idx_ready 1/0 -> remaining starts at 8; indices 0..7 each emitted once, in order; load_valid pulsed during EMIT is ignored.
REQ-034 Load 8'b1011_1010, resetN=0 after the 2nd transfer -> next cycle: idx_valid=0, remaining=0, done=0; a new load of 8'b1111_1110 then yields idx 0..6 with remaining starting at 7.
REQ-035 ONES_ITER_ABORT_EN defined: load 8'b1011_1010, assert abort with idx_ready=1 on the 3rd index -> that index is not transferred; IDLE next cycle, no done pulse.
